// File: rtl/enc_event_decoder_if.sv
`default_nettype none
// ------------------------------------------------------------------
// enc_event_decoder_if : event-in / result-out AXIS bundle (rev 1.0)
// ------------------------------------------------------------------
interface enc_event_decoder_if #(
  parameter int POS_W = 32,
  parameter int DT_W  = 32
);
  logic [95:0]           s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [POS_W+DT_W+7:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid,
    output m_axis_tready
  );
endinterface
`default_nettype wire

// File: rtl/enc_event_decoder.sv
`default_nettype none
// ------------------------------------------------------------------
// enc_event_decoder : quadrature event decoder, position + dt (rev 1.0)
// ------------------------------------------------------------------
module enc_event_decoder #(
  parameter int POS_W = 32,
  parameter int DT_W  = 32  // must stay below the 94-bit timestamp width
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               pos_clear,
  enc_event_decoder_if.slave      bus,
  output logic      [POS_W-1:0]   position,
  output logic      [15:0]        illegal_cnt
);

  localparam int TS_W  = 94;
  localparam int OUT_W = POS_W + DT_W + 8;

  typedef enum logic [0:0] {
    STATE_INIT  = 1'b0,
    STATE_TRACK = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         prev_enc;
  logic [TS_W-1:0]    prev_ts;
  logic               out_valid;
  logic [OUT_W-1:0]   out_data;

  logic               accept;
  logic [1:0]         enc_new;
  logic [TS_W-1:0]    ts_new;
  logic [TS_W-1:0]    ts_diff;
  logic               fwd;
  logic               rev;
  logic               illegal;
  logic               first;
  logic [DT_W-1:0]    dt;
  logic [POS_W-1:0]   pos_base;
  logic [POS_W-1:0]   pos_nxt;
  logic [OUT_W-1:0]   result;

  assign bus.s_axis_tready = !out_valid || bus.m_axis_tready;
  assign bus.m_axis_tvalid = out_valid;
  assign bus.m_axis_tdata  = out_data;

  assign accept  = bus.s_axis_tvalid && bus.s_axis_tready;
  assign enc_new = bus.s_axis_tdata[95:94];
  assign ts_new  = bus.s_axis_tdata[TS_W-1:0];
  assign ts_diff = ts_new - prev_ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STATE_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fwd       = 1'b0;
    rev       = 1'b0;
    illegal   = 1'b0;
    first     = 1'b0;
    dt        = '0;
    case (state)
      STATE_INIT: begin
        first = 1'b1;
        if (accept) state_nxt = STATE_TRACK;
      end
      STATE_TRACK: begin
        dt = (|ts_diff[TS_W-1:DT_W]) ? '1 : ts_diff[DT_W-1:0];
        // Gray-code step {prev, new}: one bit flipped is a step, both is a glitch
        case ({prev_enc, enc_new})
          4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd     = 1'b1;
          4'b0010, 4'b1011, 4'b1101, 4'b0100: rev     = 1'b1;
          4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
          default: ;
        endcase
      end
      default: state_nxt = STATE_INIT;
    endcase

    pos_base = pos_clear ? '0 : position;
    pos_nxt  = pos_base;
    if (accept && fwd)      pos_nxt = pos_base + POS_W'(1);
    else if (accept && rev) pos_nxt = pos_base - POS_W'(1);

    result = {5'b0, first, illegal, fwd, pos_nxt, dt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_enc    <= '0;
      prev_ts     <= '0;
      position    <= '0;
      illegal_cnt <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      if (accept) begin
        prev_enc <= enc_new;
        prev_ts  <= ts_new;
        out_data <= result;
      end
      if (accept || pos_clear) position <= pos_nxt;
      if (accept && illegal && (illegal_cnt != 16'hFFFF))
        illegal_cnt <= illegal_cnt + 16'd1;
      if (accept)                 out_valid <= 1'b1;
      else if (bus.m_axis_tready) out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_enc_event_decoder.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_enc_event_decoder : randomized scoreboard bench (rev 1.0)
// ------------------------------------------------------------------
module tb_enc_event_decoder;

  localparam int POS_W = 32;
  localparam int DT_W  = 32;
  localparam int OW    = POS_W + DT_W + 8;
  localparam logic [93:0] DT_MAX = {{(94-DT_W){1'b0}}, {DT_W{1'b1}}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pos_clear = 1'b0;
  logic [POS_W-1:0] position;
  logic [15:0]      illegal_cnt;

  enc_event_decoder_if #(.POS_W(POS_W), .DT_W(DT_W)) bus();

  enc_event_decoder #(.POS_W(POS_W), .DT_W(DT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .pos_clear   (pos_clear),
    .bus         (bus.slave),
    .position    (position),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [OW-1:0] exp_q[$];

  // reference model state
  bit             m_have = 0;
  logic [1:0]     m_enc  = '0;
  logic [93:0]    m_ts   = '0;
  logic [POS_W-1:0] m_pos = '0;
  int             m_icnt = 0;

  logic [1:0]  enc_now = '0;
  logic [93:0] ts_now  = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // position of a state around the quadrature cycle 00 -> 01 -> 11 -> 10
  function automatic int gidx(input logic [1:0] e);
    case (e)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] fwd_of(input logic [1:0] e);
    case (e)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_apply(input logic [1:0] enc, input logic [93:0] ts, input bit clr);
    logic [93:0]     d;
    logic [DT_W-1:0] dtv;
    bit fst, ill, dir;
    int steps;
    fst = 0; ill = 0; dir = 0; dtv = '0;
    if (clr) m_pos = '0;
    if (!m_have) begin
      fst = 1;
    end else begin
      d   = ts - m_ts;
      dtv = (d > DT_MAX) ? {DT_W{1'b1}} : d[DT_W-1:0];
      steps = (gidx(enc) - gidx(m_enc)) & 3;
      if (steps == 1) begin
        m_pos = m_pos + 1;
        dir = 1;
      end else if (steps == 3) begin
        m_pos = m_pos - 1;
      end else if (steps == 2) begin
        ill = 1;
        if (m_icnt < 65535) m_icnt++;
      end
    end
    m_have = 1;
    m_enc  = enc;
    m_ts   = ts;
    exp_q.push_back({5'b0, fst, ill, dir, m_pos, dtv});
  endtask

  // one clock of stimulus; inputs change at posedge+1, decisions made at negedge
  task automatic step(input bit v, input logic [1:0] enc, input logic [93:0] ts,
                      input bit clr, input bit mr, output bit took);
    bus.s_axis_tvalid = v;
    bus.s_axis_tdata  = {enc, ts};
    pos_clear         = clr;
    bus.m_axis_tready = mr;
    @(negedge clk);
    chk("position", position, m_pos);
    chk("illegal_cnt", illegal_cnt, m_icnt[15:0]);
    took = v && bus.s_axis_tready;
    if (took)     model_apply(enc, ts, clr);
    else if (clr) m_pos = '0;
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    pos_clear = 1'b0;
  endtask

  task automatic send(input logic [1:0] enc, input logic [93:0] ts, input bit clr, input bit rnd);
    bit took;
    took = 0;
    for (int i = 0; i < 64 && !took; i++)
      step(1'b1, enc, ts, clr, rnd ? ($urandom_range(0, 3) != 0) : 1'b1, took);
    if (!took) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: beat not accepted in 64 cycles");
    end
  endtask

  task automatic idle(input int n, input bit clr);
    bit took;
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, clr, 1'b1, took);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1, 1'b0);
    idle(1, 1'b0);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic fsend(input bit clr);
    enc_now = fwd_of(enc_now);
    ts_now  = ts_now + 94'd3;
    send(enc_now, ts_now, clr, 1'b0);
  endtask

  // monitor: pops expected results on every output handshake, checks hold
  bit          hold_v = 0;
  logic [OW-1:0] hold_w;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", bus.m_axis_tvalid, 1);
        chk("hold_data", bus.m_axis_tdata, hold_w);
      end
      if (bus.m_axis_tvalid) begin
        if (bus.m_axis_tready) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL result_unexpected: got %0h with empty scoreboard", bus.m_axis_tdata);
          end else begin
            chk("result", bus.m_axis_tdata, exp_q.pop_front());
          end
        end
        hold_v = !bus.m_axis_tready;
        hold_w = bus.m_axis_tdata;
      end else begin
        hold_v = 0;
      end
    end
  end

  initial begin
    bit took;
    int nt;
    int r;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.m_axis_tready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_m_valid", bus.m_axis_tvalid, 0);
    chk("rst_m_data", bus.m_axis_tdata, 0);
    chk("rst_position", position, 0);
    chk("rst_illegal_cnt", illegal_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", bus.s_axis_tready, 1);
    @(posedge clk); #1;

    // basic forward sequence
    send(2'b00, 94'd100, 0, 0);
    send(2'b01, 94'd110, 0, 0);
    send(2'b11, 94'd125, 0, 0);
    send(2'b10, 94'd145, 0, 0);
    drain();
    chk("fwd_position", position, 32'd3);

    // reverse from 00
    send(2'b00, 94'd150, 0, 0);
    idle(1, 1'b1);
    send(2'b10, 94'd160, 0, 0);
    send(2'b11, 94'd170, 0, 0);
    drain();
    chk("rev_position", position, 32'hFFFFFFFE);

    // illegal then reverse
    send(2'b01, 94'd180, 0, 0);
    send(2'b10, 94'd190, 0, 0);
    drain();
    chk("illegal_cnt_one", illegal_cnt, 16'd1);
    send(2'b11, 94'd200, 0, 0);
    drain();
    chk("after_illegal_pos", position, 32'hFFFFFFFC);

    // dt saturation and timestamp wrap
    send(2'b11, 94'd200 + (94'd1 << 40), 0, 0);
    send(2'b11, {94{1'b1}} - 94'd4, 0, 0);
    send(2'b11, 94'd3, 0, 0);
    drain();
    enc_now = 2'b11;
    ts_now  = 94'd3;

    // stall with tvalid held: exactly one beat taken, then back-to-back
    nt = 0;
    ts_now = ts_now + 94'd7;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, enc_now, ts_now, 0, 1'b0, took);
      nt += took;
    end
    chk("stall_accepts", nt, 1);
    chk("stall_s_ready", bus.s_axis_tready, 0);
    nt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        enc_now = fwd_of(enc_now);
        ts_now  = ts_now + 94'd7;
      end
      step(1'b1, enc_now, ts_now, 0, 1'b1, took);
      nt += took;
    end
    chk("b2b_accepts", nt, 6);
    drain();

    // clear coincident with a forward beat at position 57
    idle(1, 1'b1);
    for (int i = 0; i < 57; i++) fsend(0);
    drain();
    chk("pos_57", position, 32'd57);
    fsend(1);
    drain();
    chk("clear_with_beat", position, 32'd1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1, $urandom_range(0, 19) == 0);
      end else begin
        r = $urandom_range(0, 49);
        if (r == 0)      ts_now = ts_now + (94'd1 << 40) + 94'($urandom_range(0, 99));
        else if (r == 1) ts_now = {94{1'b1}} - 94'($urandom_range(0, 10));
        else if (r != 2) ts_now = ts_now + 94'($urandom_range(1, 5000));
        enc_now = 2'($urandom_range(0, 3));
        send(enc_now, ts_now, $urandom_range(0, 29) == 0, 1'b1);
      end
    end
    drain();

    // asynchronous reset with an output beat pending
    step(1'b1, 2'b01, ts_now + 94'd1, 0, 1'b0, took);
    chk("pre_reset_took", took, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.m_axis_tvalid, 0);
    chk("async_rst_data", bus.m_axis_tdata, 0);
    exp_q.delete();
    m_have = 0; m_enc = '0; m_ts = '0; m_pos = '0; m_icnt = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", bus.s_axis_tready, 1);
    @(posedge clk); #1;
    send(2'b10, 94'd42, 0, 0);
    send(2'b00, 94'd50, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
